// File: rtl/frame_collector.sv
// frame_collector: converts signed fixed-point activations to 8-bit pixels,
// assembles them into ping-pong frame banks and streams each full frame out
// over a valid/ready interface with m_last marking the final pixel.
module frame_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int IMG_W      = 23,
  parameter int IMG_H      = 23
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [7:0]            m_data,
  output logic                  m_last,
  output logic                  frame_done,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  localparam int N      = IMG_W * IMG_H;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int ADDR_W = $clog2(2 * N);
  localparam int SHIFT  = FRAC_BITS - 7;

  localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0]  FRAME_LEN  = CNT_W'(N);
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(N);

  typedef enum logic {R_IDLE, R_DRAIN} rstate_e;

  logic [7:0] mem [0:2*N-1];

  rstate_e           state_q, state_d;
  logic [1:0]        full_q, full_d;
  logic              wrBank_q, wrBank_d;
  logic              rdBank_q, rdBank_d;
  logic [CNT_W-1:0]  wrCnt_q, wrCnt_d;
  logic [CNT_W-1:0]  rdCnt_q, rdCnt_d;
  logic              mValid_q, mValid_d;
  logic              mLast_q, mLast_d;
  logic [7:0]        mData_q, mData_d;
  logic              frameDone_q, frameDone_d;
  logic              overflow_q, overflow_d;

  logic signed [DATA_WIDTH-1:0] shifted;
  logic signed [DATA_WIDTH:0]   biased;
  logic [7:0]                   pixel;
  logic                         writeEn;
  logic                         dropEn;
  logic [ADDR_W-1:0]            wrAddr;
  logic [ADDR_W-1:0]            rdAddr;

  // Scale the sample down to 8 significant bits, re-centre on 128 and clamp.
  always_comb begin
    shifted = $signed(data_in) >>> SHIFT;
    biased  = {shifted[DATA_WIDTH-1], shifted} + (DATA_WIDTH+1)'(128);
    if (biased[DATA_WIDTH]) begin
      pixel = 8'd0;
    end else if (|biased[DATA_WIDTH-1:8]) begin
      pixel = 8'd255;
    end else begin
      pixel = biased[7:0];
    end
  end

  // A sample lands only in a bank that is not waiting to be drained.
  always_comb begin
    writeEn = valid_in && !full_q[wrBank_q];
    dropEn  = valid_in &&  full_q[wrBank_q];
    wrAddr  = (wrBank_q ? BANK1_BASE : ADDR_W'(0)) + ADDR_W'(wrCnt_q);
    rdAddr  = (rdBank_q ? BANK1_BASE : ADDR_W'(0)) + ADDR_W'(rdCnt_q);
  end

  // Pixel storage; never reset, the full flags say what is valid.
  always_ff @(posedge clk) begin
    if (writeEn) begin
      mem[wrAddr] <= pixel;
    end
  end

  // Next-state logic for the write side, overflow flag and read FSM.
  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    wrBank_d    = wrBank_q;
    rdBank_d    = rdBank_q;
    wrCnt_d     = wrCnt_q;
    rdCnt_d     = rdCnt_q;
    mValid_d    = mValid_q;
    mLast_d     = mLast_q;
    mData_d     = mData_q;
    frameDone_d = 1'b0;
    overflow_d  = overflow_q;

    if (writeEn) begin
      if (wrCnt_q == LAST_IDX) begin
        full_d[wrBank_q] = 1'b1;
        wrBank_d         = ~wrBank_q;
        wrCnt_d          = '0;
      end else begin
        wrCnt_d = wrCnt_q + CNT_W'(1);
      end
    end

    if (clear_overflow) begin
      overflow_d = 1'b0;
    end
    if (dropEn) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      R_IDLE: begin
        if (full_q[rdBank_q]) begin
          state_d = R_DRAIN;
          rdCnt_d = '0;
        end
      end
      R_DRAIN: begin
        if (mValid_q && m_ready) begin
          mValid_d = 1'b0;
          mLast_d  = 1'b0;
          if (mLast_q) begin
            full_d[rdBank_q] = 1'b0;
            rdBank_d         = ~rdBank_q;
            frameDone_d      = 1'b1;
            state_d          = R_IDLE;
          end
        end
        if ((!mValid_q || m_ready) && (rdCnt_q != FRAME_LEN)) begin
          mValid_d = 1'b1;
          mData_d  = mem[rdAddr];
          mLast_d  = (rdCnt_q == LAST_IDX);
          rdCnt_d  = rdCnt_q + CNT_W'(1);
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // State register with asynchronous clear of every control and output bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= R_IDLE;
      full_q      <= '0;
      wrBank_q    <= 1'b0;
      rdBank_q    <= 1'b0;
      wrCnt_q     <= '0;
      rdCnt_q     <= '0;
      mValid_q    <= 1'b0;
      mLast_q     <= 1'b0;
      mData_q     <= '0;
      frameDone_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wrBank_q    <= wrBank_d;
      rdBank_q    <= rdBank_d;
      wrCnt_q     <= wrCnt_d;
      rdCnt_q     <= rdCnt_d;
      mValid_q    <= mValid_d;
      mLast_q     <= mLast_d;
      mData_q     <= mData_d;
      frameDone_q <= frameDone_d;
      overflow_q  <= overflow_d;
    end
  end

  assign m_valid    = mValid_q;
  assign m_last     = mLast_q;
  assign m_data     = mData_q;
  assign frame_done = frameDone_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_frame_collector.sv
// tb_frame_collector: directed frames against a frame-level reference model
// (accepted pixels grouped into frames, at most two frames held) plus
// hand-computed pixel, latency and flag expectations.
module tb_frame_collector;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int W  = 23;
  localparam int H  = 23;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          m_ready = 1'b0;
  logic          clear_overflow = 1'b0;
  logic          m_valid;
  logic [7:0]    m_data;
  logic          m_last;
  logic          frame_done;
  logic          overflow;

  frame_collector #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB), .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .frame_done(frame_done), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model state
  int doneQ[$];
  int wrQ[$];
  int pending = 0;
  int headIdx = 0;
  bit fdExp = 1'b0;
  bit ovExp = 1'b0;
  bit prevValid = 1'b0;
  bit dropNow;
  bit hsNow;

  // Observation counters used by the directed checks
  int fdCount = 0;
  int capIdx = 0;
  int lastCnt = 0;
  int lastIdx = -1;
  int validCycles = 0;
  int firstValidCyc = -1;
  int lastInCyc = 0;
  int capPix [0:2*N-1];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pixOf(logic [DW-1:0] d);
    int v;
    int dv;
    int q;
    v  = int'($signed(d));
    dv = 1 << (FB - 7);
    if (v >= 0) q = v / dv;
    else        q = -((-v + dv - 1) / dv);
    q = q + 128;
    if (q < 0)   q = 0;
    if (q > 255) q = 255;
    return q;
  endfunction

  function automatic logic [DW-1:0] dataOf(int pat, int i);
    int pix;
    if (pat == 0) begin
      case (i)
        0:       return 16'h0100;
        1:       return 16'hFF00;
        3:       return 16'h7FFF;
        4:       return 16'h8000;
        default: return 16'h0000;
      endcase
    end
    case (pat)
      1:       pix = i % 256;
      2:       pix = (i + 100) % 256;
      3:       pix = (i * 3) % 256;
      4:       pix = (i * 5) % 256;
      default: pix = 255 - (i % 256);
    endcase
    return DW'(pix * 2 - 256);
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(logic v, logic [DW-1:0] d);
    valid_in = v;
    data_in  = d;
    if (v) lastInCyc = cyc;
    tick();
  endtask

  task automatic sendFrame(int pat, int gap);
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b1, dataOf(pat, i));
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, '0);
    end
    valid_in = 1'b0;
  endtask

  task automatic waitFrames(int target, int budget);
    int k;
    k = 0;
    while (fdCount < target && k < budget) begin
      tick();
      k++;
    end
    checkOutput("frameCount", fdCount, target);
  endtask

  task automatic clearCaps();
    capIdx        = 0;
    lastCnt       = 0;
    lastIdx       = -1;
    validCycles   = 0;
    firstValidCyc = -1;
  endtask

  // Every cycle: compare outputs with the model, then advance the model
  // by the handshake and input that the coming rising edge will take.
  always @(negedge clk) begin
    if (!rst_n) begin
      doneQ.delete();
      wrQ.delete();
      pending   = 0;
      headIdx   = 0;
      fdExp     = 1'b0;
      ovExp     = 1'b0;
      prevValid = 1'b0;
    end else begin
      checkOutput("frame_done", int'(frame_done), int'(fdExp));
      checkOutput("overflow", int'(overflow), int'(ovExp));
      checkOutput("lastQualified", int'(m_last && !m_valid), 0);
      if (m_valid) begin
        checkOutput("validHasFrame", int'(pending > 0), 1);
        if (pending > 0) begin
          checkOutput("pixel", int'(m_data), doneQ[0]);
          checkOutput("m_last", int'(m_last), int'(headIdx == N - 1));
        end
        validCycles++;
        if (!prevValid) firstValidCyc = cyc;
      end
      if (frame_done) fdCount++;
      prevValid = m_valid;

      dropNow = valid_in && (pending == 2);
      hsNow   = m_valid && m_ready && (pending > 0);
      fdExp   = 1'b0;
      if (hsNow) begin
        if (capIdx < 2 * N) capPix[capIdx] = int'(m_data);
        capIdx++;
        if (m_last) begin
          lastCnt++;
          lastIdx = capIdx - 1;
        end
        void'(doneQ.pop_front());
        headIdx++;
        if (headIdx == N) begin
          headIdx = 0;
          pending--;
          fdExp = 1'b1;
        end
      end
      if (clear_overflow) ovExp = 1'b0;
      if (dropNow)        ovExp = 1'b1;
      if (valid_in && !dropNow) begin
        wrQ.push_back(pixOf(data_in));
        if (wrQ.size() == N) begin
          foreach (wrQ[j]) doneQ.push_back(wrQ[j]);
          wrQ.delete();
          pending++;
        end
      end
    end
  end

  initial begin
    int k;
    int fdBase;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstValid", int'(m_valid), 0);
    checkOutput("rstData", int'(m_data), 0);
    checkOutput("rstLast", int'(m_last), 0);
    checkOutput("rstDone", int'(frame_done), 0);
    checkOutput("rstOvf", int'(overflow), 0);
    rst_n = 1'b1;
    tick();

    // Conversion frame with the consumer always ready
    $display("[TB] conversion frame");
    m_ready = 1'b1;
    clearCaps();
    fdBase = fdCount;
    sendFrame(0, 0);
    waitFrames(fdBase + 1, N + 20);
    repeat (4) tick();
    checkOutput("convPix0", capPix[0], 255);
    checkOutput("convPix1", capPix[1], 0);
    checkOutput("convPix2", capPix[2], 128);
    checkOutput("convPix3", capPix[3], 255);
    checkOutput("convPix4", capPix[4], 0);
    checkOutput("convPix528", capPix[528], 128);
    checkOutput("convLastCnt", lastCnt, 1);
    checkOutput("convLastIdx", lastIdx, 528);
    checkOutput("convDoneOnce", fdCount, fdBase + 1);
    checkOutput("convLatency", firstValidCyc - lastInCyc, 3);
    checkOutput("convNoBubble", validCycles, N);

    // Ramp frame with a five-cycle stall on pixel 10
    $display("[TB] stall frame");
    clearCaps();
    fdBase = fdCount;
    sendFrame(1, 0);
    k = 0;
    while (!(m_valid && m_data == 8'd10) && k < 100) begin
      tick();
      k++;
    end
    checkOutput("stallReach", int'(m_valid && m_data == 8'd10), 1);
    m_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      checkOutput("stallData", int'(m_data), 10);
      checkOutput("stallValid", int'(m_valid), 1);
    end
    m_ready = 1'b1;
    waitFrames(fdBase + 1, N + 30);
    checkOutput("stallCount", capIdx, N);
    checkOutput("stallPix10", capPix[10], 10);
    checkOutput("stallPix11", capPix[11], 11);
    checkOutput("stallPix300", capPix[300], 44);
    checkOutput("stallNoBubble", validCycles, N + 5);

    // Two frames held, a third dropped, then both drained in order
    $display("[TB] ping-pong");
    m_ready = 1'b0;
    clearCaps();
    fdBase = fdCount;
    sendFrame(1, 0);
    sendFrame(2, 0);
    tick();
    checkOutput("ppOvfClear", int'(overflow), 0);
    checkOutput("ppValid", int'(m_valid), 1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, dataOf(3, i));
    valid_in = 1'b0;
    checkOutput("ppOvfSet", int'(overflow), 1);
    m_ready = 1'b1;
    waitFrames(fdBase + 2, 2 * N + 40);
    checkOutput("ppCount", capIdx, 2 * N);
    checkOutput("ppA0", capPix[0], 0);
    checkOutput("ppA528", capPix[528], 16);
    checkOutput("ppB0", capPix[N], 100);
    checkOutput("ppB528", capPix[N + 528], 116);

    // Overflow clear alone, then clear colliding with a drop
    $display("[TB] overflow clear");
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    checkOutput("ovfCleared", int'(overflow), 0);
    m_ready = 1'b0;
    clearCaps();
    sendFrame(3, 0);
    sendFrame(4, 0);
    checkOutput("ovfStill0", int'(overflow), 0);
    valid_in = 1'b1;
    data_in = 16'h1234;
    clear_overflow = 1'b1;
    tick();
    valid_in = 1'b0;
    clear_overflow = 1'b0;
    checkOutput("ovfSetWins", int'(overflow), 1);

    // Asynchronous reset while pixel 200 is on the output
    $display("[TB] reset mid-drain");
    m_ready = 1'b1;
    k = 0;
    while (!(m_valid && capIdx == 200) && k < 400) begin
      tick();
      k++;
    end
    checkOutput("reach200", capIdx, 200);
    checkOutput("pix200", int'(m_data), 88);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arstValid", int'(m_valid), 0);
    checkOutput("arstData", int'(m_data), 0);
    checkOutput("arstLast", int'(m_last), 0);
    checkOutput("arstDone", int'(frame_done), 0);
    checkOutput("arstOvf", int'(overflow), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clearCaps();
    fdBase = fdCount;
    sendFrame(5, 0);
    waitFrames(fdBase + 1, N + 20);
    checkOutput("freshLatency", firstValidCyc - lastInCyc, 3);
    checkOutput("freshCount", capIdx, N);
    checkOutput("freshPix0", capPix[0], 255);
    checkOutput("freshPixLast", capPix[N - 1], 239);

    // Sparse input, one sample every third cycle
    $display("[TB] sparse input");
    clearCaps();
    fdBase = fdCount;
    sendFrame(1, 2);
    waitFrames(fdBase + 1, N + 20);
    checkOutput("sparseLatency", firstValidCyc - lastInCyc, 3);
    checkOutput("sparseCount", capIdx, N);
    checkOutput("sparsePix5", capPix[5], 5);
    checkOutput("sparsePixLast", capPix[N - 1], 16);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
